arbitro_escrita: RTL and testbench

ARBITRO_ESCRITA -- requirements
Module: arbitro_escrita

---
 rtl/arbitro_escrita_pkg.sv | 11 +
 rtl/arbitro_escrita_fila.sv | 50 +++++
 rtl/arbitro_escrita.sv | 102 ++++++++++
 tb/tb_arbitro_escrita.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_escrita_pkg.sv
// arbitro_escrita_pkg: shared sizes and writeback source encoding
package arbitro_escrita_pkg;
    localparam int NUM_REG   = 32;
    localparam int LARG_END  = 5;
    localparam int LARG_DADO = 32;
    localparam int PROF_FILA = 2;
    typedef enum logic {
        FONTE_ALU = 1'b0,
        FONTE_MEM = 1'b1
    } fonte_t;
endpackage

// File: rtl/arbitro_escrita_fila.sv
// fila_escrita: small circular FIFO holding pending writebacks of one source
module fila_escrita #(
    parameter int LARG = 37,
    parameter int PROF = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [LARG-1:0] dado_i,
    output logic            pronto_o,
    output logic            vazia_o,
    output logic [LARG-1:0] cabeca_o
);
    localparam int LP = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int LC = $clog2(PROF + 1);
    logic [LARG-1:0] mem_q [PROF];
    logic [LP-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [LC-1:0]   cnt_q, cnt_d;

    function automatic logic [LP-1:0] prox(input logic [LP-1:0] p);
        return (p == LP'(PROF - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_d     = pop_i ? prox(rd_q) : rd_q;
        wr_d     = push_i ? prox(wr_q) : wr_q;
        cnt_d    = cnt_q + LC'(push_i) - LC'(pop_i);
        pronto_o = cnt_q != LC'(PROF);
        vazia_o  = cnt_q == '0;
        cabeca_o = mem_q[rd_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // contents need no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= dado_i;
    end
endmodule

// File: rtl/arbitro_escrita.sv
// arbitro_escrita: round-robin writeback arbiter between ALU and load paths
// with a per-register pending-write scoreboard for decode hazard detection.
module arbitro_escrita
    import arbitro_escrita_pkg::*;
#(
    parameter int NUM_REG   = arbitro_escrita_pkg::NUM_REG,
    parameter int LARG_DADO = arbitro_escrita_pkg::LARG_DADO,
    parameter int PROF_FILA = arbitro_escrita_pkg::PROF_FILA
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [LARG_END-1:0]  alu_end,
    input  logic [LARG_DADO-1:0] alu_dado,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [LARG_END-1:0]  mem_end,
    input  logic [LARG_DADO-1:0] mem_dado,
    input  logic                 reserva_valid,
    input  logic [LARG_END-1:0]  reserva_end,
    output logic                 reserva_ok,
    input  logic [LARG_END-1:0]  consulta1,
    input  logic [LARG_END-1:0]  consulta2,
    output logic                 conflito,
    output logic [LARG_END-1:0]  endRegDest,
    output logic [LARG_DADO-1:0] dado,
    output logic                 sinalEscrita,
    output logic                 erro
);
    localparam int LE = LARG_END + LARG_DADO;
    logic [LE-1:0]        cab_a, cab_m;
    logic                 vaz_a, vaz_m, push_a, push_m, g_a, g_m;
    logic                 inc, dec, mesmo;
    logic [LARG_END-1:0]  gend, end_q, end_d;
    logic [LARG_DADO-1:0] gdado, dado_q, dado_d;
    logic                 sinal_q, sinal_d, erro_q, erro_d;
    logic [1:0]           cnt_q [NUM_REG];
    logic [1:0]           cnt_d [NUM_REG];
    fonte_t               ult_q, ult_d;

    assign push_a = alu_valid & alu_ready;
    assign push_m = mem_valid & mem_ready;

    fila_escrita #(.LARG(LE), .PROF(PROF_FILA)) u_fila_alu (
        .clk(clk), .reset(reset), .push_i(push_a), .pop_i(g_a),
        .dado_i({alu_end, alu_dado}), .pronto_o(alu_ready),
        .vazia_o(vaz_a), .cabeca_o(cab_a)
    );

    fila_escrita #(.LARG(LE), .PROF(PROF_FILA)) u_fila_mem (
        .clk(clk), .reset(reset), .push_i(push_m), .pop_i(g_m),
        .dado_i({mem_end, mem_dado}), .pronto_o(mem_ready),
        .vazia_o(vaz_m), .cabeca_o(cab_m)
    );

    always_comb begin
        g_a           = ~vaz_a & (vaz_m | (ult_q == FONTE_MEM));
        g_m           = ~vaz_m & ~g_a;
        {gend, gdado} = g_a ? cab_a : cab_m;
        ult_d         = g_a ? FONTE_ALU : (g_m ? FONTE_MEM : ult_q);
        reserva_ok    = cnt_q[reserva_end] != 2'd3;
        conflito      = (cnt_q[consulta1] != 2'd0) | (cnt_q[consulta2] != 2'd0);
        dec           = (g_a | g_m) & (gend != '0);
        inc           = reserva_valid & reserva_ok & (reserva_end != '0);
        // a reservation and a write to the same register cancel out
        mesmo         = inc & dec & (reserva_end == gend);
        erro_d        = erro_q | (dec & ~mesmo & (cnt_q[gend] == 2'd0));
        sinal_d       = dec;
        end_d         = (g_a | g_m) ? gend : end_q;
        dado_d        = (g_a | g_m) ? gdado : dado_q;
        for (int i = 0; i < NUM_REG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!mesmo && inc && reserva_end == LARG_END'(i)) cnt_d[i] = cnt_q[i] + 2'd1;
            if (!mesmo && dec && gend == LARG_END'(i) && cnt_q[i] != 2'd0) cnt_d[i] = cnt_q[i] - 2'd1;
        end
        cnt_d[0] = 2'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ult_q   <= FONTE_MEM;
            erro_q  <= 1'b0;
            sinal_q <= 1'b0;
            end_q   <= '0;
            dado_q  <= '0;
            cnt_q   <= '{default: 2'd0};
        end else begin
            ult_q   <= ult_d;
            erro_q  <= erro_d;
            sinal_q <= sinal_d;
            end_q   <= end_d;
            dado_q  <= dado_d;
            cnt_q   <= cnt_d;
        end
    end

    assign endRegDest   = end_q;
    assign dado         = dado_q;
    assign sinalEscrita = sinal_q;
    assign erro         = erro_q;
endmodule

// File: tb/tb_arbitro_escrita.sv
// tb_arbitro_escrita: queue-based reference model with scoreboarded write port
module tb_arbitro_escrita;
    typedef struct packed {logic [4:0] e; logic [31:0] d;} ent_t;
    typedef struct packed {int c; logic [4:0] e; logic [31:0] d;} exp_t;

    logic        clk = 0, reset = 1;
    logic        alu_valid = 0, mem_valid = 0, reserva_valid = 0;
    logic [4:0]  alu_end = 0, mem_end = 0, reserva_end = 0, consulta1 = 0, consulta2 = 0;
    logic [31:0] alu_dado = 0, mem_dado = 0;
    logic        alu_ready, mem_ready, reserva_ok, conflito, sinalEscrita, erro;
    logic [4:0]  endRegDest;
    logic [31:0] dado;

    arbitro_escrita dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_end(alu_end), .alu_dado(alu_dado),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_end(mem_end), .mem_dado(mem_dado),
        .reserva_valid(reserva_valid), .reserva_end(reserva_end), .reserva_ok(reserva_ok),
        .consulta1(consulta1), .consulta2(consulta2), .conflito(conflito),
        .endRegDest(endRegDest), .dado(dado), .sinalEscrita(sinalEscrita), .erro(erro)
    );

    always #5 clk = ~clk;

    int   checks = 0, errors = 0, cyc = 0;
    ent_t sa[$], sm[$], qa[$], qm[$];
    exp_t expq[$];
    int   cnt [32];
    int   last;
    bit   erro_m, rv_g;
    logic [4:0] re_g, c1_g, c2_g;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: obtido=%0h esperado=%0h (ciclo %0d)", nome, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sa.delete(); sm.delete(); qa.delete(); qm.delete(); expq.delete();
        foreach (cnt[i]) cnt[i] = 0;
        last = 1;
        erro_m = 0;
    endtask

    task automatic ciclo();
        bit ar, mr, rok, ga, gm, mesmo;
        ent_t h;
        @(negedge clk);
        alu_valid = sa.size() > 0;
        if (alu_valid) {alu_end, alu_dado} = sa[0];
        mem_valid = sm.size() > 0;
        if (mem_valid) {mem_end, mem_dado} = sm[0];
        reserva_valid = rv_g;
        reserva_end = re_g;
        consulta1 = c1_g;
        consulta2 = c2_g;
        #1;
        chk("alu_ready", alu_ready, qa.size() < 2);
        chk("mem_ready", mem_ready, qm.size() < 2);
        chk("reserva_ok", reserva_ok, cnt[reserva_end] < 3);
        chk("conflito", conflito, cnt[consulta1] != 0 || cnt[consulta2] != 0);
        chk("erro", erro, erro_m);
        @(posedge clk);
        ar = qa.size() < 2;
        mr = qm.size() < 2;
        rok = cnt[reserva_end] < 3;
        ga = qa.size() > 0 && (qm.size() == 0 || last == 1);
        gm = qm.size() > 0 && !ga;
        mesmo = 0;
        cyc++;
        if (ga || gm) begin
            if (ga) h = qa.pop_front();
            else h = qm.pop_front();
            last = ga ? 0 : 1;
            if (h.e != 0) begin
                expq.push_back('{cyc, h.e, h.d});
                mesmo = reserva_valid && rok && reserva_end == h.e;
                if (!mesmo) begin
                    if (cnt[h.e] == 0) erro_m = 1;
                    else cnt[h.e]--;
                end
            end
        end
        if (reserva_valid && rok && reserva_end != 0 && !mesmo) cnt[reserva_end]++;
        if (alu_valid && ar) qa.push_back(sa.pop_front());
        if (mem_valid && mr) qm.push_back(sm.pop_front());
        rv_g = 0;
    endtask

    task automatic reservar(input logic [4:0] e);
        rv_g = 1;
        re_g = e;
        ciclo();
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sinalEscrita) begin
                if (expq.size() == 0) chk("escrita_inesperada", {27'd0, endRegDest}, 32'd0);
                else begin
                    x = expq.pop_front();
                    chk("ciclo_escrita", cyc, x.c);
                    chk("endRegDest", {27'd0, endRegDest}, {27'd0, x.e});
                    chk("dado", dado, x.d);
                end
            end else if (expq.size() > 0 && expq[0].c == cyc) begin
                chk("escrita_faltante", 0, 1);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        rv_g = 0; re_g = 0; c1_g = 0; c2_g = 0;
        model_reset();
        #2 reset = 0;
        #1;
        chk("rst_sinal", sinalEscrita, 0);
        chk("rst_end", {27'd0, endRegDest}, 0);
        chk("rst_dado", dado, 0);
        chk("rst_erro", erro, 0);
        @(negedge clk) reset = 1;

        // contention: alu wins the first tie after reset
        for (int i = 0; i < 3; i++) begin reservar(3); reservar(4); end
        for (int i = 0; i < 3; i++) begin
            sa.push_back('{5'd3, 32'h300 + i});
            sm.push_back('{5'd4, 32'h400 + i});
        end
        repeat (9) ciclo();

        // single write
        reservar(5);
        sa.push_back('{5'd5, 32'hA5A5A5A5});
        repeat (4) ciclo();

        // backpressure on mem while alu saturates
        for (int i = 0; i < 3; i++) begin reservar(10); reservar(11); reservar(12); end
        for (int i = 0; i < 6; i++) sa.push_back('{(i < 3) ? 5'd10 : 5'd12, $urandom});
        for (int i = 0; i < 3; i++) sm.push_back('{5'd11, $urandom});
        repeat (14) ciclo();

        // scoreboard: hazard on r7, reserve and write on the same edge
        c1_g = 7;
        reservar(7);
        reservar(7);
        sa.push_back('{5'd7, 32'h7001});
        ciclo();
        reservar(7);
        sa.push_back('{5'd7, 32'h7002});
        repeat (2) ciclo();
        sa.push_back('{5'd7, 32'h7003});
        repeat (4) ciclo();
        c1_g = 0;

        // $zero never written; unreserved write flags a sticky error
        sa.push_back('{5'd0, 32'hDEAD0000});
        repeat (3) ciclo();
        sm.push_back('{5'd9, 32'h9999});
        repeat (4) ciclo();

        // reset with writes still queued
        for (int i = 0; i < 2; i++) begin
            sa.push_back('{5'd20, 32'h2000 + i});
            sm.push_back('{5'd21, 32'h2100 + i});
        end
        repeat (2) ciclo();
        @(negedge clk);
        reset = 0;
        alu_valid = 0;
        mem_valid = 0;
        #1;
        chk("rst_meio_sinal", sinalEscrita, 0);
        chk("rst_meio_end", {27'd0, endRegDest}, 0);
        chk("rst_meio_dado", dado, 0);
        chk("rst_meio_erro", erro, 0);
        model_reset();
        repeat (3) begin @(posedge clk); cyc++; end
        @(negedge clk) reset = 1;
        repeat (3) ciclo();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && sa.size() < 4)
                sa.push_back('{5'($urandom_range(0, 7)), $urandom});
            if ($urandom_range(0, 2) == 0 && sm.size() < 4)
                sm.push_back('{5'($urandom_range(0, 7)), $urandom});
            if ($urandom_range(0, 1) == 0) begin rv_g = 1; re_g = 5'($urandom_range(0, 7)); end
            c1_g = 5'($urandom_range(0, 7));
            c2_g = 5'($urandom_range(0, 7));
            ciclo();
        end
        repeat (20) ciclo();
        chk("fila_esperada_vazia", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
